game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//   Top-level game-flow controller for space invaders. Sequences the sprite datapath (player, laser,
//   invaders, missiles) through attract, play, hit-pause, wave-clear and game-over phases. Drives a
//   run enable that freezes sprite motion, plus restart/wave-reload pulses and a level number.
//   Sits beside score_logic in the clk_pixel domain; consumes frame, lives, invaders and collisions.
// PARAMETERS
//   HIT_FRAMES    60  frames the game freezes after the player is hit (1..255)
//   WAVE_FRAMES   120 frames of pause between a cleared wave and the reload (1..255)
//   NUM_INVADERS  55  width of the invaders alive vector
//   LEVEL_W       3   width of level counter; saturates at 2**LEVEL_W-1
// PORTS
//   clk          in   1             clk_pixel; all logic on rising edge
//   rst          in   1             synchronous, active-high reset
//   arst         in   1             debounced reset button, level; acts as soft restart
//   frame        in   1             one-cycle pulse per VGA frame
//   start        in   1             debounced shoot button, level; rising edge detected internally
//   lives        in   2             lives remaining from score_logic
//   invaders     in   NUM_INVADERS  alive mask; bit=1 invader alive
//   player_hit   in   1             OR of player_collision bits, any-cycle pulse or level
//   run          out  1             1 = sprites may move/fire; 0 = freeze positions
//   game_rst     out  1             one-cycle pulse: reset lives/score/sprites for a new game
//   wave_rst     out  1             one-cycle pulse: reload invader grid for next wave
//   level        out  LEVEL_W       current wave number, 0 = first wave
//   state        out  3             encoded state (ATTRACT=0 PLAY=1 HIT=2 WAVE_CLEAR=3 GAME_OVER=4)
//   blink_en     out  1             1 in ATTRACT and GAME_OVER (vga overlay blinks)
// BEHAVIOUR
//   - All outputs registered. Reset values: state=ATTRACT, run=0, game_rst=0, wave_rst=0, level=0,
//     blink_en=1, frame counter=0, start-edge register=0.
//   - Priority per cycle: rst > arst > state transition logic.
//   - arst=1 (any state): next state ATTRACT, level=0, run=0, game_rst=1 every cycle arst is held.
//   - start_edge = start & ~start_q (start_q registered each cycle, also cleared by rst).
//   - ATTRACT: run=0. start_edge -> game_rst pulse (1 cycle), level=0, enter PLAY.
//   - PLAY: run=1. Inputs sampled every cycle; player_hit has priority over wave clear.
//       player_hit=1 -> HIT, counter=HIT_FRAMES, run=0 from next cycle.
//       else frame=1 and invaders=={NUM_INVADERS{1'b0}} and play_armed -> WAVE_CLEAR, counter=WAVE_FRAMES.
//       play_armed clears on PLAY entry, sets on the first frame pulse seen in PLAY (guards against
//       stale zero mask while invaders reloads after wave_rst/game_rst).
//   - HIT: run=0; counter decrements on each frame pulse. When counter==1 and frame=1:
//       lives==0 -> GAME_OVER; else -> PLAY. player_hit ignored in HIT.
//       lives are sampled at exit, so score_logic's decrement has settled by then.
//   - WAVE_CLEAR: run=0; counter decrements on frame. At exit (counter==1, frame=1): wave_rst=1
//     for exactly one cycle, level<=level+1 saturating at max, -> PLAY.
//   - GAME_OVER: run=0, blink_en=1. start_edge -> game_rst pulse, level=0, -> PLAY.
//   - Latency: qualifying input at cycle N -> new state/outputs visible cycle N+1.
//   - Counter is 8 bits; never underflows (load >=1, exits at 1).
//   - start held from ATTRACT into PLAY produces no second edge; releasing and pressing is required
//     to leave GAME_OVER.
//   - Illegal state encodings (5..7) recover to ATTRACT on the next cycle, run=0.
// TESTING
//   1 rst=1 2 cycles -> state=0 run=0 level=0 game_rst=0 wave_rst=0 blink_en=1.
//   2 ATTRACT, start 0->1 -> game_rst=1 for 1 cycle, state=1 run=1; start held high 100 cycles -> no
//     further game_rst.
//   3 PLAY lives=2, player_hit 1 cycle -> state=2 run=0; after exactly 60 frame pulses state=1 run=1.
//   4 PLAY lives=0, player_hit -> HIT; after 60 frames state=4 blink_en=1; new start edge -> game_rst,
//     state=1, level=0.
//   5 PLAY, invaders=0 at frame -> state=3; after 120 frames wave_rst 1 cycle, level 0->1, state=1;
//     repeat 9 waves -> level saturates at 7.
//   6 Same cycle player_hit=1 and invaders=0 -> state=2 (hit wins). arst mid-WAVE_CLEAR -> state=0,
//     level=0, game_rst high while arst held, no wave_rst.

Source files
------------

// File: rtl/game_sequencer.sv
// Space invaders game-flow controller: attract, play, hit pause,
// wave clear and game over, with run gating and restart pulses.
module game_sequencer #(
  parameter int HIT_FRAMES   = 60,
  parameter int WAVE_FRAMES  = 120,
  parameter int NUM_INVADERS = 55,
  parameter int LEVEL_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arst,
  input  logic                    frame,
  input  logic                    start,
  input  logic [1:0]              lives,
  input  logic [NUM_INVADERS-1:0] invaders,
  input  logic                    player_hit,
  output logic                    run,
  output logic                    game_rst,
  output logic                    wave_rst,
  output logic [LEVEL_W-1:0]      level,
  output logic [2:0]              state,
  output logic                    blink_en
);

  typedef enum logic [2:0] {
    ATTRACT    = 3'd0,
    PLAY       = 3'd1,
    HIT        = 3'd2,
    WAVE_CLEAR = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] HIT_LOAD  = 8'(HIT_FRAMES);
  localparam logic [7:0] WAVE_LOAD = 8'(WAVE_FRAMES);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  state_t             cur;
  state_t             nxt;
  logic [7:0]         cnt;
  logic [7:0]         cnt_n;
  logic [LEVEL_W-1:0] level_n;
  logic               armed;
  logic               armed_n;
  logic               start_q;
  logic               start_edge;
  logic               game_rst_n;
  logic               wave_rst_n;
  logic               run_n;
  logic               blink_n;
  logic               all_dead;

  assign start_edge = start & ~start_q;
  assign all_dead   = (invaders == '0);
  assign state      = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= ATTRACT;
      cnt      <= '0;
      level    <= '0;
      armed    <= 1'b0;
      start_q  <= 1'b0;
      run      <= 1'b0;
      game_rst <= 1'b0;
      wave_rst <= 1'b0;
      blink_en <= 1'b1;
    end else begin
      cur      <= nxt;
      cnt      <= cnt_n;
      level    <= level_n;
      armed    <= armed_n;
      start_q  <= start;
      run      <= run_n;
      game_rst <= game_rst_n;
      wave_rst <= wave_rst_n;
      blink_en <= blink_n;
    end
  end

  always_comb begin
    nxt        = cur;
    cnt_n      = cnt;
    level_n    = level;
    armed_n    = armed;
    game_rst_n = 1'b0;
    wave_rst_n = 1'b0;
    if (arst) begin
      nxt        = ATTRACT;
      level_n    = '0;
      armed_n    = 1'b0;
      game_rst_n = 1'b1;
    end else begin
      unique case (cur)
        ATTRACT, GAME_OVER: begin
          if (start_edge) begin
            nxt        = PLAY;
            level_n    = '0;
            armed_n    = 1'b0;
            game_rst_n = 1'b1;
          end
        end
        PLAY: begin
          // An all-zero mask only counts once a frame has passed in PLAY,
          // so a grid still reloading is not mistaken for a cleared wave.
          if (player_hit) begin
            nxt   = HIT;
            cnt_n = HIT_LOAD;
          end else if (frame && all_dead && armed) begin
            nxt   = WAVE_CLEAR;
            cnt_n = WAVE_LOAD;
          end else if (frame) begin
            armed_n = 1'b1;
          end
        end
        HIT: begin
          if (frame) begin
            if (cnt == 8'd1) begin
              nxt     = (lives == 2'd0) ? GAME_OVER : PLAY;
              armed_n = 1'b0;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
        WAVE_CLEAR: begin
          if (frame) begin
            if (cnt == 8'd1) begin
              nxt        = PLAY;
              armed_n    = 1'b0;
              wave_rst_n = 1'b1;
              if (level != LEVEL_MAX)
                level_n = level + 1'b1;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
        default: nxt = ATTRACT;
      endcase
    end
    run_n   = (nxt == PLAY);
    blink_n = (nxt == ATTRACT) || (nxt == GAME_OVER);
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start edges, hit pause,
// game over, wave clear with level saturation, and soft restart.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arst;
  logic        frame;
  logic        start;
  logic [1:0]  lives;
  logic [54:0] invaders;
  logic        player_hit;
  logic        run;
  logic        game_rst;
  logic        wave_rst;
  logic [2:0]  level;
  logic [2:0]  state;
  logic        blink_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .arst       (arst),
    .frame      (frame),
    .start      (start),
    .lives      (lives),
    .invaders   (invaders),
    .player_hit (player_hit),
    .run        (run),
    .game_rst   (game_rst),
    .wave_rst   (wave_rst),
    .level      (level),
    .state      (state),
    .blink_en   (blink_en)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gr_cnt;
    int wr_cnt;
    int exp_lvl;
    rst = 1'b1; arst = 1'b0; frame = 1'b0; start = 1'b0;
    lives = 2'd2; invaders = '1; player_hit = 1'b0;

    // reset
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_run", run, 0);
    chk("rst_level", level, 0);
    chk("rst_game_rst", game_rst, 0);
    chk("rst_wave_rst", wave_rst, 0);
    chk("rst_blink", blink_en, 1);
    rst = 1'b0;
    tick();
    chk("attract_idle", state, 0);

    // start edge from ATTRACT
    start = 1'b1;
    tick();
    chk("start_game_rst", game_rst, 1);
    chk("start_state", state, 1);
    chk("start_run", run, 1);
    chk("start_blink", blink_en, 0);
    gr_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (game_rst) gr_cnt++;
    end
    chk("start_held_no_rst", gr_cnt, 0);
    chk("start_held_state", state, 1);
    start = 1'b0;

    // hit with lives left
    lives = 2'd2;
    player_hit = 1'b1;
    tick();
    player_hit = 1'b0;
    chk("hit_state", state, 2);
    chk("hit_run", run, 0);
    frames(59);
    chk("hit_59", state, 2);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("hit_exit_state", state, 1);
    chk("hit_exit_run", run, 1);
    tick();

    // hit with no lives -> game over
    lives = 2'd0;
    player_hit = 1'b1;
    tick();
    player_hit = 1'b0;
    chk("hit0_state", state, 2);
    frames(60);
    chk("go_state", state, 4);
    chk("go_blink", blink_en, 1);
    chk("go_run", run, 0);
    lives = 2'd3;
    tick();
    chk("go_wait", state, 4);
    start = 1'b1;
    tick();
    chk("go_game_rst", game_rst, 1);
    chk("go_restart_state", state, 1);
    chk("go_restart_level", level, 0);
    start = 1'b0;
    tick();
    chk("go_game_rst_pulse", game_rst, 0);

    // wave clear, nine waves, level saturates at 7
    invaders = '0;
    for (int w = 1; w <= 9; w++) begin
      frames(1);
      chk("wave_armed_wait", state, 1);
      frames(1);
      chk("wave_enter", state, 3);
      chk("wave_run", run, 0);
      frames(119);
      chk("wave_119", state, 3);
      frame = 1'b1;
      tick();
      frame = 1'b0;
      exp_lvl = (w > 7) ? 7 : w;
      chk("wave_rst_pulse", wave_rst, 1);
      chk("wave_level", level, exp_lvl);
      chk("wave_exit_state", state, 1);
      tick();
      chk("wave_rst_clear", wave_rst, 0);
    end

    // hit beats wave clear in the same cycle
    frames(1);
    player_hit = 1'b1;
    frame = 1'b1;
    tick();
    player_hit = 1'b0;
    frame = 1'b0;
    chk("hit_wins", state, 2);
    frames(60);
    chk("hit_wins_back", state, 1);

    // arst during WAVE_CLEAR
    frames(2);
    chk("arst_pre_wc", state, 3);
    frames(5);
    arst = 1'b1;
    tick();
    chk("arst_state", state, 0);
    chk("arst_level", level, 0);
    chk("arst_game_rst", game_rst, 1);
    chk("arst_run", run, 0);
    gr_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 130; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      if (game_rst) gr_cnt++;
      if (wave_rst) wr_cnt++;
    end
    chk("arst_held_game_rst", gr_cnt, 130);
    chk("arst_no_wave_rst", wr_cnt, 0);
    arst = 1'b0;
    tick();
    chk("arst_release_rst", game_rst, 0);
    chk("arst_release_state", state, 0);
    chk("arst_release_blink", blink_en, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
